// File: rtl/simon_core_sched.sv
// simon_core_sched
//   Two-client round-robin scheduler in front of a single SIMON block-cipher
//   core (default 48/96: N=24, M=4). It owns every core handshake, keeps
//   one key per client, reloads the core key only when the owner, direction
//   or key content changed, and buffers one result per client.
//
// Ports
//   clk, R                      clock, synchronous active-high reset
//   key_set, key_in             per-client key write strobe and key value
//   in_valid/in_ready           per-client request handshake
//   in_enc_dec, in_block        per-client direction (1=encrypt) and block
//   out_valid/out_ready         per-client result buffer handshake
//   out_data                    per-client result buffer contents
//   newKey, newData, readData   core requests
//   enc_dec, KEY, BLOCK         core direction, key and block
//   loadKey, loadData, doneData core acknowledges
//   outData                     core result
module simon_core_sched #(
  parameter int N = 24,
  parameter int M = 4
) (
  input  logic                        clk,
  input  logic                        R,
  input  logic [1:0]                  key_set,
  input  logic [1:0][M-1:0][N-1:0]    key_in,
  input  logic [1:0]                  in_valid,
  output logic [1:0]                  in_ready,
  input  logic [1:0]                  in_enc_dec,
  input  logic [1:0][1:0][N-1:0]      in_block,
  output logic [1:0]                  out_valid,
  input  logic [1:0]                  out_ready,
  output logic [1:0][1:0][N-1:0]      out_data,
  output logic                        newKey,
  output logic                        newData,
  output logic                        readData,
  output logic                        enc_dec,
  output logic [M-1:0][N-1:0]         KEY,
  output logic [1:0][N-1:0]           BLOCK,
  input  logic                        loadKey,
  input  logic                        loadData,
  input  logic                        doneData,
  input  logic [1:0][N-1:0]           outData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_REQ,
    S_DATA_REQ,
    S_BUSY,
    S_READ
  } state_e;

  state_e                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       cur_q, cur_d;
  logic [1:0][M-1:0][N-1:0]   key_q, key_d;
  logic [1:0]                 key_ok_q, key_ok_d;
  logic [1:0]                 stale_q, stale_d;
  logic                       loaded_ok_q, loaded_ok_d;
  logic                       loaded_owner_q, loaded_owner_d;
  logic                       loaded_dir_q, loaded_dir_d;
  logic [1:0]                 out_valid_q, out_valid_d;
  logic [1:0][1:0][N-1:0]     out_data_q, out_data_d;
  logic [M-1:0][N-1:0]        core_key_q, core_key_d;
  logic [1:0][N-1:0]          core_blk_q, core_blk_d;
  logic                       core_dir_q, core_dir_d;
  // Remembers a key rewrite of the current client while its key load is
  // pending, so the load acknowledge does not wipe the new stale mark.
  logic                       kset_req_q, kset_req_d;

  logic [1:0] eligible;
  logic       grant;
  logic       accept;
  logic       reload;

  // Eligibility and arbitration depend only on registered state plus the
  // request inputs, so in_ready is a clean function of the current cycle.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      eligible[c] = (state_q == S_IDLE) & in_valid[c] & key_ok_q[c]
                  & ~out_valid_q[c] & ~key_set[c];
    end
    if (&eligible) grant = ~last_grant_q;
    else           grant = eligible[1];
    in_ready[0] = eligible[0] & ~grant & ~R;
    in_ready[1] = eligible[1] &  grant & ~R;
    accept      = |in_ready;
    reload      = ~loaded_ok_q | (loaded_owner_q != grant)
                | (loaded_dir_q != in_enc_dec[grant]) | stale_q[grant];
  end

  // NOTE: every signal written here is given its default first, so no path
  // through the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cur_d          = cur_q;
    key_d          = key_q;
    key_ok_d       = key_ok_q;
    stale_d        = stale_q;
    loaded_ok_d    = loaded_ok_q;
    loaded_owner_d = loaded_owner_q;
    loaded_dir_d   = loaded_dir_q;
    out_data_d     = out_data_q;
    core_key_d     = core_key_q;
    core_blk_d     = core_blk_q;
    core_dir_d     = core_dir_q;
    kset_req_d     = kset_req_q;
    newKey         = 1'b0;
    newData        = 1'b0;
    readData       = 1'b0;

    // Consume first; a capture below overrides it for the same client.
    out_valid_d = out_valid_q & ~out_ready;

    // Key writes are honoured in every state and force a reload later.
    for (int c = 0; c < 2; c++) begin
      if (key_set[c]) begin
        key_d[c]    = key_in[c];
        key_ok_d[c] = 1'b1;
        stale_d[c]  = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cur_d        = grant;
          core_blk_d   = in_block[grant];
          core_dir_d   = in_enc_dec[grant];
          last_grant_d = grant;
          if (reload) begin
            core_key_d = key_q[grant];
            kset_req_d = 1'b0;
            state_d    = S_KEY_REQ;
          end else begin
            state_d    = S_DATA_REQ;
          end
        end
      end
      S_KEY_REQ: begin
        newKey = 1'b1;
        if (key_set[cur_q]) kset_req_d = 1'b1;
        if (loadKey) begin
          loaded_owner_d = cur_q;
          loaded_dir_d   = core_dir_q;
          loaded_ok_d    = 1'b1;
          if (!kset_req_q && !key_set[cur_q]) stale_d[cur_q] = 1'b0;
          state_d        = S_DATA_REQ;
        end
      end
      S_DATA_REQ: begin
        newData = 1'b1;
        if (loadData) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (doneData) begin
          out_data_d[cur_q]  = outData;
          out_valid_d[cur_q] = 1'b1;
          state_d            = S_READ;
        end
      end
      S_READ: begin
        readData = 1'b1;
        if (!doneData) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the values computed in the previous cycle.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q        <= S_IDLE;
      last_grant_q   <= 1'b1;
      cur_q          <= 1'b0;
      // NOTE: the key store is small and must be wiped on reset (stored keys
      // are lost), so it is reset like any other register.
      key_q          <= '0;
      key_ok_q       <= '0;
      stale_q        <= '0;
      loaded_ok_q    <= 1'b0;
      loaded_owner_q <= 1'b0;
      loaded_dir_q   <= 1'b0;
      out_valid_q    <= '0;
      out_data_q     <= '0;
      core_key_q     <= '0;
      core_blk_q     <= '0;
      core_dir_q     <= 1'b1;
      kset_req_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cur_q          <= cur_d;
      key_q          <= key_d;
      key_ok_q       <= key_ok_d;
      stale_q        <= stale_d;
      loaded_ok_q    <= loaded_ok_d;
      loaded_owner_q <= loaded_owner_d;
      loaded_dir_q   <= loaded_dir_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      core_key_q     <= core_key_d;
      core_blk_q     <= core_blk_d;
      core_dir_q     <= core_dir_d;
      kset_req_q     <= kset_req_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign KEY       = core_key_q;
  assign BLOCK     = core_blk_q;
  assign enc_dec   = core_dir_q;

endmodule

// File: tb/tb_simon_core_sched.sv
// tb_simon_core_sched
//   Directed bench for simon_core_sched. A stand-in core answers the key,
//   data and result handshakes; it binds the direction at key load (as the
//   SIMON key schedule does) and returns the published 48/96 vectors for the
//   reference key, otherwise a simple keyed mixing function.
module tb_simon_core_sched;

  localparam int N = 24;
  localparam int M = 4;

  localparam logic [95:0] K0 = 96'h1A1918_121110_0A0908_020100;
  localparam logic [47:0] P0 = 48'h726963_20646E;
  localparam logic [47:0] C0 = 48'h6E06A5_ACF156;
  localparam logic [95:0] K1 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;

  logic                     clk;
  logic                     R;
  logic [1:0]               key_set;
  logic [1:0][M-1:0][N-1:0] key_in;
  logic [1:0]               in_valid;
  logic [1:0]               in_ready;
  logic [1:0]               in_enc_dec;
  logic [1:0][1:0][N-1:0]   in_block;
  logic [1:0]               out_valid;
  logic [1:0]               out_ready;
  logic [1:0][1:0][N-1:0]   out_data;
  logic                     newKey, newData, readData, enc_dec;
  logic [M-1:0][N-1:0]      KEY;
  logic [1:0][N-1:0]        BLOCK;
  logic                     loadKey, loadData, doneData;
  logic [1:0][N-1:0]        outData;

  int n_checks = 0;
  int n_fail   = 0;
  int nk_rises = 0;
  int proto_viol = 0;
  int ready1_viol = 0;
  bit nokey_phase = 0;

  simon_core_sched #(.N(N), .M(M)) dut (
    .clk(clk), .R(R), .key_set(key_set), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_enc_dec(in_enc_dec),
    .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .newKey(newKey), .newData(newData),
    .readData(readData), .enc_dec(enc_dec), .KEY(KEY), .BLOCK(BLOCK),
    .loadKey(loadKey), .loadData(loadData), .doneData(doneData),
    .outData(outData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] core_fn(input logic [95:0] k, input logic d,
                                          input logic [47:0] b);
    if (k == K0 && d && b == P0)  return C0;
    if (k == K0 && !d && b == C0) return P0;
    return b ^ k[47:0] ^ k[95:48] ^ (d ? 48'hA5A5A5_5A5A5A : 48'h3C3C3C_C3C3C3);
  endfunction

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in core: one-cycle acknowledges, a few cycles of compute.
  initial begin
    logic [95:0] ckey;
    logic        cdir;
    logic [47:0] cblk;
    int          cnt;
    loadKey = 0; loadData = 0; doneData = 0; outData = '0;
    ckey = '0; cdir = 1'b1; cblk = '0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (R) begin
        loadKey = 0; loadData = 0; doneData = 0; cnt = 0;
      end else begin
        if (loadKey) loadKey = 0;
        else if (newKey) begin loadKey = 1; ckey = KEY; cdir = enc_dec; end
        if (loadData) begin loadData = 0; cnt = 4; end
        else if (newData) begin loadData = 1; cblk = BLOCK; end
        if (doneData && readData) doneData = 0;
        else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin doneData = 1; outData = core_fn(ckey, cdir, cblk); end
        end
      end
    end
  end

  // Protocol monitor: newKey pulses, request overlap, keyless grants.
  initial begin
    logic nk_prev;
    nk_prev = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (newKey && !nk_prev) nk_rises++;
      nk_prev = newKey;
      if (newKey && newData) proto_viol++;
      if (nokey_phase && in_ready[1]) ready1_viol++;
    end
  end

  task automatic do_reset();
    @(negedge clk); R = 1'b1;
    @(negedge clk); R = 1'b0;
  endtask

  task automatic set_key(input int c, input logic [95:0] k);
    @(negedge clk); key_set[c] = 1'b1; key_in[c] = k;
    @(negedge clk); key_set[c] = 1'b0;
  endtask

  task automatic wait_result(input int c, input logic [47:0] exp,
                             input string tag, input bit consume);
    int n;
    n = 0;
    while (!out_valid[c] && n < 100) begin @(negedge clk); n++; end
    check({tag, "_out_valid"}, out_valid[c], 1'b1);
    check({tag, "_out_data"}, out_data[c], exp);
    if (consume) begin
      out_ready[c] = 1'b1;
      @(negedge clk);
      out_ready[c] = 1'b0;
    end
  endtask

  task automatic do_req(input int c, input logic dir, input logic [47:0] blk,
                        input logic [95:0] key, input logic exp_reload,
                        input bit consume, input bit kset_busy, input string tag);
    int n;
    @(negedge clk);
    in_enc_dec[c] = dir; in_block[c] = blk; in_valid[c] = 1'b1;
    #1; n = 0;
    while (!in_ready[c] && n < 50) begin @(negedge clk); #1; n++; end
    check({tag, "_accept"}, in_ready[c], 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid[c] = 1'b0;
    check({tag, "_newKey"}, newKey, exp_reload);
    check({tag, "_newData"}, newData, !exp_reload);
    if (kset_busy) begin
      n = 0; while (!newData && n < 50) begin @(negedge clk); n++; end
      n = 0; while (newData && n < 50) begin @(negedge clk); n++; end
      key_set[c] = 1'b1; key_in[c] = key;
      @(negedge clk);
      key_set[c] = 1'b0;
    end
    wait_result(c, core_fn(key, dir, blk), tag, consume);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 2'b00);
    check({tag, "_out_valid"}, out_valid, 2'b00);
    check({tag, "_reqs"}, {newKey, newData, readData}, 3'b000);
    check({tag, "_enc_dec"}, enc_dec, 1'b1);
    check({tag, "_KEY"}, KEY, 96'h0);
    check({tag, "_BLOCK"}, BLOCK, 48'h0);
    check({tag, "_out_data"}, out_data, 96'h0);
  endtask

  initial begin
    int nk0, v, g, cyc;
    int idx[2];
    int res[2];
    bit upd[2];
    logic [47:0] rr_blk [2][4];

    R = 1'b1; key_set = '0; key_in = '0; in_valid = '0; in_enc_dec = '0;
    in_block = '0; out_ready = '0;
    repeat (2) @(negedge clk);
    R = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Reference vector, then direction change, then a warm repeat.
    set_key(0, K0);
    nk0 = nk_rises;
    do_req(0, 1'b1, P0, K0, 1'b1, 1'b1, 1'b0, "enc_ref");
    check("enc_ref_newKey_count", nk_rises - nk0, 1);
    do_req(0, 1'b0, C0, K0, 1'b1, 1'b1, 1'b0, "dec_reload");
    nk0 = nk_rises;
    do_req(0, 1'b0, C0, K0, 1'b0, 1'b1, 1'b0, "dec_warm");
    check("dec_warm_newKey_count", nk_rises - nk0, 0);

    // Key rewrite while busy: result unaffected, next request reloads.
    do_req(0, 1'b1, P0, K0, 1'b1, 1'b1, 1'b1, "kset_busy");
    do_req(0, 1'b1, P0, K0, 1'b1, 1'b1, 1'b0, "stale_reload");

    // Round robin with both clients on the same key.
    do_reset();
    set_key(0, K1);
    set_key(1, K1);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) rr_blk[c][i] = {8'(c + 1), 8'(i), 32'h0BAD_F00D};
      idx[c] = 0; res[c] = 0; upd[c] = 1'b0;
    end
    in_block[0] = rr_blk[0][0]; in_block[1] = rr_blk[1][0];
    in_enc_dec = 2'b11; out_ready = 2'b11;
    nk0 = nk_rises; g = 0; cyc = 0;
    while ((res[0] < 4 || res[1] < 4) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) in_valid = 2'b11;
      for (int c = 0; c < 2; c++) begin
        if (upd[c]) begin
          upd[c] = 1'b0;
          if (idx[c] < 4) in_block[c] = rr_blk[c][idx[c]];
          else            in_valid[c] = 1'b0;
        end
      end
      #1;
      for (int c = 0; c < 2; c++) begin
        if (out_valid[c] && out_ready[c] && res[c] < 4) begin
          check($sformatf("rr_data_c%0d_%0d", c, res[c]), out_data[c],
                core_fn(K1, 1'b1, rr_blk[c][res[c]]));
          res[c]++;
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (in_valid[c] && in_ready[c]) begin
          check($sformatf("rr_grant_%0d", g), c, g % 2);
          g++; idx[c]++; upd[c] = 1'b1;
        end
      end
    end
    check("rr_done", (res[0] == 4) && (res[1] == 4), 1'b1);
    check("rr_newKey_count", nk_rises - nk0, 8);
    in_valid = '0; out_ready = '0;

    // Client 1 has no key but keeps requesting.
    do_reset();
    set_key(0, K0);
    @(negedge clk);
    in_valid[1] = 1'b1;
    nokey_phase = 1'b1;
    do_req(0, 1'b1, P0, K0, 1'b1, 1'b1, 1'b0, "nokey_c0");

    // Full result buffer blocks the next request until consumed.
    do_req(0, 1'b1, 48'h111111_222222, K0, 1'b0, 1'b0, 1'b0, "bp1");
    @(negedge clk);
    in_block[0] = 48'h333333_444444; in_enc_dec[0] = 1'b1; in_valid[0] = 1'b1;
    v = 0;
    repeat (4) begin @(negedge clk); #1; if (in_ready[0]) v++; end
    check("bp_hold", v, 0);
    check("bp_out_valid_held", out_valid[0], 1'b1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    #1;
    check("bp_ready_after_consume", in_ready[0], 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp2_newData", newData, 1'b1);
    wait_result(0, core_fn(K0, 1'b1, 48'h333333_444444), "bp2", 1'b1);
    nokey_phase = 1'b0;
    in_valid[1] = 1'b0;
    check("nokey_ready1", ready1_viol, 0);

    // Reset while busy, then a keyless request after reset is refused.
    @(negedge clk);
    in_block[0] = 48'h555555_666666; in_enc_dec[0] = 1'b1; in_valid[0] = 1'b1;
    #1; v = 0;
    while (!in_ready[0] && v < 50) begin @(negedge clk); #1; v++; end
    check("rst_busy_accept", in_ready[0], 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid[0] = 1'b0;
    v = 0; while (!newData && v < 50) begin @(negedge clk); v++; end
    v = 0; while (newData && v < 50) begin @(negedge clk); v++; end
    R = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_busy");
    R = 1'b0;
    in_valid[0] = 1'b1;
    v = 0;
    repeat (6) begin @(negedge clk); #1; if (in_ready[0]) v++; end
    check("rst_refuse_no_key", v, 0);
    in_valid[0] = 1'b0;

    check("no_newKey_newData_overlap", proto_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_core_sched.md
# simon_core_sched

Two-client round-robin scheduler that shares one SIMON block-cipher core (48/96 default: N=24, M=4) between two independent requesters. It sits directly in front of the core.

- **Owns** all core handshakes: newKey/loadKey, newData/loadData, doneData/readData.
- **Stores** one key per client and reloads the core key only when needed.
- **Buffers** one result per client.

## Interface
Parameters:
- N, 24, word size in bits; block is 2N.
- M, 4, key words; key is M*N bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- R  in  1  synchronous active-high reset. The same wrapper drives the core's nR = ~R.
- key_set  in  [1:0]  per-client key write strobe.
- key_in  in  [1:0][M-1:0][N-1:0]  per-client key, sampled when key_set[c]=1.
- in_valid  in  [1:0]  client request valid.
- in_ready  out  [1:0]  request accepted on cycles where in_valid[c] & in_ready[c].
- in_enc_dec  in  [1:0]  1=encrypt, 0=decrypt.
- in_block  in  [1:0][1:0][N-1:0]  input block.
- out_valid  out  [1:0]  result buffer full.
- out_ready  in  [1:0]  client consumes result on cycles where out_valid[c] & out_ready[c].
- out_data  out  [1:0][1:0][N-1:0]  result buffer contents.
- newKey, newData, readData  out  1 each  core requests.
- enc_dec  out  1  core direction.
- KEY  out  [M-1:0][N-1:0]  core key.
- BLOCK  out  [1:0][N-1:0]  core block.
- loadKey, loadData, doneData  in  1 each  core acknowledges.
- outData  in  [1:0][N-1:0]  core result.

## Operation
**Per-client state**
- key_reg[c] and key_ok[c].
- key_set[c] writes key_reg[c] and sets key_ok[c]=1 and stale[c]=1, in any state.

**Eligibility and arbitration**
- Client c is eligible when state=IDLE, in_valid[c], key_ok[c], !out_valid[c], and !key_set[c].
- Round-robin via last_grant (reset 1, so client 0 wins the first tie). When both are eligible, grant !last_grant. When one is eligible, grant it.
- in_ready[c] = eligible[c] & grant==c, combinational from registered state. At most one in_ready bit is high per cycle.

**Accept cycle**
- Latch cur=c, cur_blk=in_block[c], cur_dir=in_enc_dec[c], last_grant=c.
- Reload is needed when any of these hold: !loaded_ok, loaded_owner!=c, loaded_dir!=in_enc_dec[c], stale[c].
- Next state is KEY_REQ if reload is needed, else DATA_REQ.

**State machine** (IDLE, KEY_REQ, DATA_REQ, BUSY, READ):
- IDLE: all core requests low.
- KEY_REQ: newKey=1, KEY=key_reg[cur], enc_dec=cur_dir. On loadKey=1:
  - set loaded_owner=cur, loaded_dir=cur_dir, loaded_ok=1, clear stale[cur];
  - go to DATA_REQ.
- DATA_REQ: newData=1, BLOCK=cur_blk, enc_dec=cur_dir. On loadData=1, go to BUSY.
- BUSY: requests low, BLOCK/KEY/enc_dec held. On doneData=1:
  - out_data[cur]=outData, out_valid[cur]=1;
  - go to READ.
- READ: readData=1. On doneData=0, go to IDLE; readData is low from the next cycle.

**Other rules**
- KEY, BLOCK and enc_dec stay stable from KEY_REQ/DATA_REQ entry until IDLE re-entry.
- out_valid[c] clears on out_ready[c]. If a capture and a consume hit the same c in the same cycle, the capture wins (the buffer must have been empty at grant, so this cannot occur legally).
- key_set[cur] while the block is BUSY does not alter the in-flight operation. It sets stale[cur], forcing a reload on that client's next request.
- An unused key word is never sent. A client without key_ok is never granted.

## Timing
- Reset values:
  - state=IDLE, last_grant=1;
  - key_ok, stale, out_valid, loaded_ok = 0;
  - newKey, newData, readData, in_ready = 0;
  - enc_dec=1;
  - KEY, BLOCK, out_data = 0.
- Accept at cycle A. The first core request (newKey or newData) is high at A+1.
- newKey falls the cycle after loadKey is sampled high, and newData rises that same cycle.
- newData falls the cycle after loadData is sampled high.
- out_valid rises the cycle after doneData is sampled high, together with readData.
- Scheduler overhead per op excluding core latency:
  - 2 cycles without a key reload;
  - 3 cycles plus core key-load time with a reload.
- The earliest next accept is the cycle IDLE is re-entered.
- Reset asserted in any state returns the block to IDLE on the next edge with all outputs at reset values. The in-flight result is discarded, stored keys are lost, and the core is reset simultaneously.
- The block never raises newKey and newData in the same cycle. readData is only high in READ.

## Test plan
- Key 1A1918_121110_0A0908_020100 via key_set[0], encrypt 72696320646E on client 0:
  - out_data[0]=6E06A5ACF156;
  - newKey asserted once.
- Same client and key, decrypt 6E06A5ACF156: key reloaded (direction change), out_data[0]=72696320646E. Then decrypt again with the same key and direction: no newKey pulse.
- Both clients valid continuously, same key, four requests each: grant order 0,1,0,1,…. Each switch of client forces newKey. All results match the core model.
- Client 1 never sets a key, in_valid[1]=1: in_ready[1] stays 0 and client 0 is served normally.
- out_ready[0]=0 with out_valid[0]=1 and a new client-0 request pending: in_ready[0]=0 until out_ready[0] pulses, then accepted the next cycle.
- Assert R during BUSY: next cycle state=IDLE, all outputs at reset values. A subsequent request before key_set is refused.
